nfc_acs_cmdaddr_issuer: RTL

- Responder end of the ACG command/address path. It executes one atomic command-or-address sequence (ACG command bit 3) requested by NFC_Command_* executors.
- Latches CASelect/CAData/NumOfData/TargetWay, then drives NAND asynchronous-SDR pin signals (CE#, CLE, ALE, WE#, DQ) byte by byte with programmable tWP/tWH/post-wait timing.
- Reports completion with a one-cycle oLastStep, which feeds iACG_LastStep[3], and reports availability on oReady, which feeds iACG_Ready[3].

---
 rtl/nfc_acg_pkg.sv | 28 ++
 rtl/nfc_phase_timer.sv | 20 ++
 rtl/nfc_acs_cmdaddr_issuer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nfc_acg_pkg.sv
// Shared definitions for the ACG command/address responders: ACG bit map,
// issuer state encoding and address-byte limits.
package nfc_acg_pkg;

  localparam int ACG_ACS = 3;
  localparam int ACG_DIS = 1;
  localparam int ACG_ACA = 6;

  localparam int MAX_ADDR_BYTES = 5;
  localparam int CADATA_W       = 40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WE_LOW  = 3'd1,
    ST_WE_HIGH = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } issuer_state_t;

  // Command mode always sends one byte; address mode sends numOfData+1, capped.
  function automatic logic [2:0] byteCountLoad(input logic caSelect,
                                               input logic [15:0] numOfData);
    if (caSelect) return 3'd1;
    if (numOfData >= 16'(MAX_ADDR_BYTES - 1)) return 3'(MAX_ADDR_BYTES);
    return {1'b0, numOfData[1:0]} + 3'd1;
  endfunction

endpackage

// File: rtl/nfc_phase_timer.sv
// Loadable 4-bit down-counter; oZero marks the last cycle of the current phase.
module nfc_phase_timer (
  input  logic       iSystemClock,
  input  logic       iReset,
  input  logic       iLoad,
  input  logic [3:0] iLoadValue,
  output logic       oZero
);

  logic [3:0] count;

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset)             count <= 4'd0;
    else if (iLoad)         count <= iLoadValue;
    else if (count != 4'd0) count <= count - 4'd1;
  end

  assign oZero = (count == 4'd0);

endmodule

// File: rtl/nfc_acs_cmdaddr_issuer.sv
// Executes one CLE or ALE byte sequence on the NAND async-SDR pins with
// programmable tWP/tWH/post-wait, then pulses oLastStep.
module nfc_acs_cmdaddr_issuer
  import nfc_acg_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int TWP          = 3,
  parameter int TWH          = 2,
  parameter int TPOST        = 4
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iStart,
  input  logic                    iCASelect,
  input  logic [CADATA_W-1:0]     iCAData,
  input  logic [15:0]             iNumOfData,
  input  logic [NumberOfWays-1:0] iTargetWay,
  output logic                    oReady,
  output logic                    oLastStep,
  output logic [NumberOfWays-1:0] oPO_CE_n,
  output logic                    oPO_CLE,
  output logic                    oPO_ALE,
  output logic                    oPO_WE_n,
  output logic [7:0]              oPO_DQ,
  output logic                    oPO_DQOE
);

  issuer_state_t           stateQ, stateD;
  logic                    caSelQ, caSelD;
  logic [CADATA_W-1:0]     dataQ, dataD;
  logic [NumberOfWays-1:0] wayQ, wayD;
  logic [2:0]              byteCntQ, byteCntD;
  logic                    timerLoad, timerZero;
  logic [3:0]              timerLoadValue;

  nfc_phase_timer uPhaseTimer (
    .iSystemClock (iSystemClock),
    .iReset       (iReset),
    .iLoad        (timerLoad),
    .iLoadValue   (timerLoadValue),
    .oZero        (timerZero)
  );

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      stateQ   <= ST_IDLE;
      caSelQ   <= 1'b0;
      dataQ    <= '0;
      wayQ     <= '0;
      byteCntQ <= 3'd0;
    end else begin
      stateQ   <= stateD;
      caSelQ   <= caSelD;
      dataQ    <= dataD;
      wayQ     <= wayD;
      byteCntQ <= byteCntD;
    end
  end

  // Next state and datapath; the timer is reloaded on every state entry.
  always_comb begin
    stateD         = stateQ;
    caSelD         = caSelQ;
    dataD          = dataQ;
    wayD           = wayQ;
    byteCntD       = byteCntQ;
    timerLoad      = 1'b0;
    timerLoadValue = 4'd0;
    case (stateQ)
      ST_IDLE: if (iStart) begin
        stateD         = ST_WE_LOW;
        caSelD         = iCASelect;
        dataD          = iCAData;
        wayD           = iTargetWay;
        byteCntD       = byteCountLoad(iCASelect, iNumOfData);
        timerLoad      = 1'b1;
        timerLoadValue = 4'(TWP - 1);
      end
      ST_WE_LOW: if (timerZero) begin
        stateD         = ST_WE_HIGH;
        timerLoad      = 1'b1;
        timerLoadValue = 4'(TWH - 1);
      end
      ST_WE_HIGH: if (timerZero) begin
        byteCntD  = byteCntQ - 3'd1;
        timerLoad = 1'b1;
        if (byteCntQ != 3'd1) begin
          stateD         = ST_WE_LOW;
          dataD          = dataQ << 8;
          timerLoadValue = 4'(TWP - 1);
        end else begin
          stateD         = ST_POST;
          timerLoadValue = 4'(TPOST - 1);
        end
      end
      ST_POST: if (timerZero) begin
        stateD    = ST_DONE;
        timerLoad = 1'b1;
      end
      default: stateD = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so pins change on the entry edge.
  logic                    readyD, lastStepD, cleD, aleD, weD, dqoeD;
  logic [NumberOfWays-1:0] ceD;
  logic [7:0]              dqD;

  always_comb begin
    readyD    = 1'b0;
    lastStepD = 1'b0;
    ceD       = '1;
    cleD      = 1'b0;
    aleD      = 1'b0;
    weD       = 1'b1;
    dqD       = dataD[CADATA_W-1 -: 8];
    dqoeD     = 1'b0;
    case (stateD)
      ST_IDLE: begin
        readyD = 1'b1;
        dqD    = 8'h00;
      end
      ST_WE_LOW, ST_WE_HIGH: begin
        ceD   = ~wayD;
        cleD  = caSelD;
        aleD  = ~caSelD;
        weD   = (stateD != ST_WE_LOW);
        dqoeD = 1'b1;
      end
      ST_POST: ceD = ~wayD;
      default: lastStepD = 1'b1;
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      oReady    <= 1'b1;
      oLastStep <= 1'b0;
      oPO_CE_n  <= '1;
      oPO_CLE   <= 1'b0;
      oPO_ALE   <= 1'b0;
      oPO_WE_n  <= 1'b1;
      oPO_DQ    <= 8'h00;
      oPO_DQOE  <= 1'b0;
    end else begin
      oReady    <= readyD;
      oLastStep <= lastStepD;
      oPO_CE_n  <= ceD;
      oPO_CLE   <= cleD;
      oPO_ALE   <= aleD;
      oPO_WE_n  <= weD;
      oPO_DQ    <= dqD;
      oPO_DQOE  <= dqoeD;
    end
  end

endmodule
